// File: rtl/gold_code_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : gold_code_scheduler
// Description : Round-robin time-sharing of one Gold code generator among
//               NREQ requesters. Each grant loads the winner's shift code,
//               waits for generator ready, then runs REPS full code periods.
//               The chip stream is returned tagged with the owner index.
//               Optional macro GOLD_SCHED_TIMEOUT_EN bounds the ready wait.
// Revision    : 1.0 - initial release
// ============================================================================
module gold_code_scheduler #(
    parameter int N       = 63,
    parameter int LENGTH  = $clog2(N),
    parameter int NREQ    = 4,
    parameter int IDX_W   = $clog2(NREQ),
    parameter int REPS    = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                   clkin,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_i,
    input  logic [NREQ*LENGTH-1:0] shift_i,
    output logic [NREQ-1:0]        gnt_o,
    output logic                   busy_o,
    output logic [LENGTH-1:0]      gen_code2_o,
    output logic                   gen_tvalid_o,
    input  logic                   gen_ready_i,
    input  logic                   gen_code_i,
    output logic                   chip_o,
    output logic                   chip_valid_o,
    output logic [IDX_W-1:0]       chip_owner_o,
    output logic                   period_start_o,
    output logic [NREQ-1:0]        done_o,
    output logic                   err_o
);
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PER_W = $clog2(REPS + 1);
    localparam logic [CNT_W-1:0] C_LAST_CHIP = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] C_CHIP_ONE  = CNT_W'(1);
    localparam logic [PER_W-1:0] C_LAST_PER  = PER_W'(REPS - 1);
    localparam logic [PER_W-1:0] C_PER_ONE   = PER_W'(1);
    localparam logic [IDX_W-1:0] C_LAST_IDX  = IDX_W'(NREQ - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_RDY = 3'd2,
        S_RUN      = 3'd3,
        S_RELEASE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_owner;
    logic [IDX_W-1:0]  r_last_grant;
    logic [IDX_W-1:0]  r_chip_owner;
    logic [LENGTH-1:0] r_code;
    logic [CNT_W-1:0]  r_chip_cnt;
    logic [PER_W-1:0]  r_per_cnt;
    logic [NREQ-1:0]   r_done;
    logic              r_chip_valid;
    logic              r_period_start;

    logic              w_any_req;
    logic [IDX_W-1:0]  w_winner;
    logic [NREQ-1:0]   w_owner_oh;
    logic              w_active;
    logic              w_abandon;
    logic              w_last_chip;
    logic              w_grant;
    logic              w_start_run;
    logic              w_finish;

    assign w_owner_oh  = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
    assign w_active    = r_state inside {S_LOAD, S_WAIT_RDY, S_RUN};
    assign w_abandon   = w_active && !req_i[r_owner];
    assign w_last_chip = (r_chip_cnt == C_LAST_CHIP) && (r_per_cnt == C_LAST_PER);

    // Round-robin search: first requester strictly after the last grant, wrapping
    always_comb begin
        w_any_req = 1'b0;
        w_winner  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!w_any_req && req_i[IDX_W'((int'(r_last_grant) + i) % NREQ)]) begin
                w_any_req = 1'b1;
                w_winner  = IDX_W'((int'(r_last_grant) + i) % NREQ);
            end
        end
    end

`ifdef GOLD_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] C_WAIT_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [TMO_W-1:0] C_WAIT_ONE  = TMO_W'(1);
    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_err;
    logic             w_timeout;
`endif

    // Next-state decode; abandonment takes priority over every other exit
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_start_run = 1'b0;
        w_finish    = 1'b0;
`ifdef GOLD_SCHED_TIMEOUT_EN
        w_timeout   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = w_abandon ? S_RELEASE : S_WAIT_RDY;
            end
            S_WAIT_RDY: begin
                if (w_abandon) begin
                    w_state_nxt = S_RELEASE;
                end else if (gen_ready_i) begin
                    w_start_run = 1'b1;
                    w_state_nxt = S_RUN;
`ifdef GOLD_SCHED_TIMEOUT_EN
                end else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_RELEASE;
`endif
                end
            end
            S_RUN: begin
                if (w_abandon) begin
                    w_state_nxt = S_RELEASE;
                end else if (w_last_chip) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping, latched shift code and chip/period counters
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_owner      <= '0;
            r_last_grant <= C_LAST_IDX;
            r_code       <= '0;
            r_chip_cnt   <= '0;
            r_per_cnt    <= '0;
            r_done       <= '0;
        end else begin
            r_done <= w_finish ? w_owner_oh : '0;
            if (w_grant) begin
                r_owner <= w_winner;
                r_code  <= shift_i[w_winner*LENGTH +: LENGTH];
            end
            if (r_state == S_RELEASE) begin
                r_last_grant <= r_owner;
            end
            if (w_start_run) begin
                r_chip_cnt <= '0;
                r_per_cnt  <= '0;
            end else if (r_state == S_RUN) begin
                if (r_chip_cnt == C_LAST_CHIP) begin
                    r_chip_cnt <= '0;
                    r_per_cnt  <= r_per_cnt + C_PER_ONE;
                end else begin
                    r_chip_cnt <= r_chip_cnt + C_CHIP_ONE;
                end
            end
        end
    end

    // Output tags delayed one cycle to line up with the generator's registered chip
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_chip_valid   <= 1'b0;
            r_period_start <= 1'b0;
            r_chip_owner   <= '0;
        end else begin
            r_chip_valid   <= (r_state == S_RUN);
            r_period_start <= (r_state == S_RUN) && (r_chip_cnt == '0);
            r_chip_owner   <= r_owner;
        end
    end

`ifdef GOLD_SCHED_TIMEOUT_EN
    // Consecutive not-ready cycles in WAIT_RDY; zero on every entry
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (r_state != S_WAIT_RDY) begin
                r_wait_cnt <= '0;
            end else begin
                r_wait_cnt <= r_wait_cnt + C_WAIT_ONE;
            end
        end
    end
    assign err_o = r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign err_o = 1'b0;
`endif

    assign gnt_o          = w_active ? w_owner_oh : '0;
    assign busy_o         = (r_state != S_IDLE);
    assign gen_code2_o    = r_code;
    assign gen_tvalid_o   = (r_state == S_RUN);
    assign chip_valid_o   = r_chip_valid;
    assign chip_o         = r_chip_valid & gen_code_i;
    assign chip_owner_o   = r_chip_owner;
    assign period_start_o = r_period_start;
    assign done_o         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gold_code_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_gold_code_scheduler
// Description : Self-checking bench for gold_code_scheduler: directed grant,
//               round-robin, abandon, stall and reset scenarios followed by
//               randomized traffic, all compared every cycle against a
//               grant-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gold_code_scheduler;
    localparam int N       = 63;
    localparam int LENGTH  = 6;
    localparam int NREQ    = 4;
    localparam int IDX_W   = 2;
    localparam int REPS    = 2;
    localparam int TIMEOUT = 64;
    localparam int RUN_LEN = N * REPS;

    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_WAIT = 2;
    localparam int P_RUN  = 3;
    localparam int P_REL  = 4;

    logic                   clkin = 1'b0;
    logic                   rst   = 1'b1;
    logic [NREQ-1:0]        req   = '0;
    logic [NREQ*LENGTH-1:0] shift = '0;
    logic                   ready = 1'b0;
    logic                   gen_code = 1'b0;

    logic [NREQ-1:0]   gnt_o;
    logic              busy_o;
    logic [LENGTH-1:0] gen_code2_o;
    logic              gen_tvalid_o;
    logic              chip_o;
    logic              chip_valid_o;
    logic [IDX_W-1:0]  chip_owner_o;
    logic              period_start_o;
    logic [NREQ-1:0]   done_o;
    logic              err_o;

    gold_code_scheduler #(
        .N(N), .LENGTH(LENGTH), .NREQ(NREQ), .IDX_W(IDX_W), .REPS(REPS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clkin          (clkin),
        .rst            (rst),
        .req_i          (req),
        .shift_i        (shift),
        .gnt_o          (gnt_o),
        .busy_o         (busy_o),
        .gen_code2_o    (gen_code2_o),
        .gen_tvalid_o   (gen_tvalid_o),
        .gen_ready_i    (ready),
        .gen_code_i     (gen_code),
        .chip_o         (chip_o),
        .chip_valid_o   (chip_valid_o),
        .chip_owner_o   (chip_owner_o),
        .period_start_o (period_start_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clkin = ~clkin;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (grant-level view) ----------------
    int              m_phase, m_owner, m_last, m_k, m_wait, m_cowner;
    logic [LENGTH-1:0] m_code;
    logic            m_cv, m_ps, m_err;
    logic [NREQ-1:0] m_done;
    bit              m_live = 0;

    always @(posedge clkin) begin
        if (rst) begin
            m_live = 1; m_phase = P_IDLE; m_owner = 0; m_last = NREQ - 1;
            m_code = '0; m_k = 0; m_wait = 0; m_cowner = 0;
            m_cv = 0; m_ps = 0; m_err = 0; m_done = '0;
        end else begin
            m_cv     = (m_phase == P_RUN);
            m_ps     = m_cv && (m_k % N == 0);
            m_cowner = m_owner;
            m_done   = '0;
            m_err    = 0;
            if (m_phase == P_IDLE) begin
                for (int i = 1; i <= NREQ; i++) begin
                    if (m_phase == P_IDLE && req[(m_last + i) % NREQ]) begin
                        m_owner = (m_last + i) % NREQ;
                        m_code  = shift[m_owner*LENGTH +: LENGTH];
                        m_phase = P_LOAD;
                    end
                end
            end else if (m_phase == P_REL) begin
                m_last  = m_owner;
                m_phase = P_IDLE;
            end else if (!req[m_owner]) begin
                m_phase = P_REL;
            end else if (m_phase == P_LOAD) begin
                m_phase = P_WAIT;
                m_wait  = 0;
            end else if (m_phase == P_WAIT) begin
                if (ready) begin
                    m_phase = P_RUN;
                    m_k     = 0;
                end
`ifdef GOLD_SCHED_TIMEOUT_EN
                else begin
                    m_wait++;
                    if (m_wait == TIMEOUT) begin
                        m_err   = 1;
                        m_phase = P_REL;
                    end
                end
`endif
            end else begin
                m_k++;
                if (m_k == RUN_LEN) begin
                    m_done[m_owner] = 1'b1;
                    m_phase = P_REL;
                end
            end
        end
    end

    logic [NREQ-1:0] exp_gnt;
    logic [NREQ-1:0] prev_gnt = '0;

    always @(negedge clkin) begin
        if (m_live) begin
            exp_gnt = '0;
            if (m_phase == P_LOAD || m_phase == P_WAIT || m_phase == P_RUN) exp_gnt[m_owner] = 1'b1;
            chk("gnt", gnt_o, exp_gnt);
            chk("busy", busy_o, m_phase != P_IDLE);
            chk("gen_code2", gen_code2_o, m_code);
            chk("tvalid", gen_tvalid_o, m_phase == P_RUN);
            chk("chip_valid", chip_valid_o, m_cv);
            chk("chip", chip_o, m_cv & gen_code);
            chk("chip_owner", chip_owner_o, m_cowner);
            chk("period_start", period_start_o, m_ps);
            chk("done", done_o, m_done);
            chk("err", err_o, m_err);
            chk("gnt_onehot0", $onehot0(gnt_o), 1);
            chk("done_subset", (done_o & ~prev_gnt) == '0, 1);
            prev_gnt = gnt_o;
        end
    end

    // random generator chip stream
    initial begin
        forever begin
            @(posedge clkin);
            #1;
            gen_code = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic int idx_of(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Observe one grant through to completion; drops all requests at done
    task automatic measure(output int ntv, output int ncv, output int nps, output int ndone,
                           output int ps_a, output int ps_b, output int lag,
                           output logic [NREQ-1:0] dval);
        int first_tv, first_cv, post, cvi;
        first_tv = -1; first_cv = -1; post = -1; cvi = 0;
        ntv = 0; ncv = 0; nps = 0; ndone = 0; ps_a = -1; ps_b = -1; dval = '0;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (gen_tvalid_o) begin
                ntv++;
                if (first_tv < 0) first_tv = c;
            end
            if (chip_valid_o) begin
                if (first_cv < 0) first_cv = c;
                if (period_start_o) begin
                    nps++;
                    if (ps_a < 0) ps_a = cvi; else if (ps_b < 0) ps_b = cvi;
                end
                cvi++;
                ncv++;
            end
            if (done_o != '0) begin
                ndone++;
                dval = done_o;
                req  = '0;
                if (post < 0) post = c;
            end
            if (post >= 0 && c >= post + 3) break;
        end
        if (post < 0) chk("measure_done_timeout", 0, 1);
        lag = first_cv - first_tv;
    endtask

    int ntv, ncv, nps, ndone, ps_a, ps_b, lag, w, n, got;
    logic [NREQ-1:0] dval;
    int exp_rr[5] = '{0, 1, 2, 3, 0};

    initial begin
        // ---- reset values ----
        do_reset();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tvalid", gen_tvalid_o, 0);
        chk("rst_code2", gen_code2_o, 0);
        chk("rst_chip_valid", chip_valid_o, 0);

        // ---- single request ----
        shift[0 +: LENGTH] = 6'd5;
        shift[LENGTH +: LENGTH] = 6'd9;
        ready = 1'b1;
        req = 4'b0001;
        tick();
        chk("single_code2", gen_code2_o, 5);
        chk("single_gnt", gnt_o, 4'b0001);
        measure(ntv, ncv, nps, ndone, ps_a, ps_b, lag, dval);
        chk("single_tvalid_cycles", ntv, 126);
        chk("single_chip_valid_cycles", ncv, 126);
        chk("single_valid_lag", lag, 1);
        chk("single_period_starts", nps, 2);
        chk("single_ps_first", ps_a, 0);
        chk("single_ps_second", ps_b, 63);
        chk("single_done_count", ndone, 1);
        chk("single_done_value", dval, 4'b0001);
        chk("single_gnt_after", gnt_o, 0);

        // ---- round robin ----
        do_reset();
        ready = 1'b1;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = 0;
            while (gnt_o == '0 && w < 300) begin tick(); w++; end
            got = idx_of(gnt_o);
            chk("rr_order", got, exp_rr[g]);
            w = 0;
            while (gnt_o != '0 && w < 300) begin tick(); w++; end
            chk("rr_release_timeout", gnt_o, 0);
        end
        req = '0;
        repeat (4) tick();

        // ---- abandon ----
        do_reset();
        ready = 1'b1;
        req = 4'b0010;
        w = 0;
        while (!gen_tvalid_o && w < 20) begin tick(); w++; end
        chk("abandon_run_started", gen_tvalid_o, 1);
        repeat (9) tick();
        req = 4'b0100;
        tick();
        chk("abandon_tvalid_low", gen_tvalid_o, 0);
        chk("abandon_no_done_a", done_o, 0);
        req = 4'b0110;
        tick();
        chk("abandon_no_done_b", done_o, 0);
        w = 0;
        while (gnt_o == '0 && w < 20) begin tick(); w++; end
        chk("abandon_next_grant", gnt_o, 4'b0100);
        req = '0;
        repeat (4) tick();

        // ---- ready stall ----
        do_reset();
        ready = 1'b0;
        req = 4'b0001;
        tick();
        n = 0;
        repeat (20) begin tick(); if (gen_tvalid_o) n++; end
        chk("stall_no_tvalid", n, 0);
        chk("stall_gnt_held", gnt_o, 4'b0001);
        ready = 1'b1;
        measure(ntv, ncv, nps, ndone, ps_a, ps_b, lag, dval);
        chk("stall_tvalid_cycles", ntv, 126);
        chk("stall_done_count", ndone, 1);

        // ---- reset mid-RUN ----
        do_reset();
        ready = 1'b1;
        req = 4'b0001;
        measure(ntv, ncv, nps, ndone, ps_a, ps_b, lag, dval);
        req = 4'b0011;
        w = 0;
        while (!gen_tvalid_o && w < 20) begin tick(); w++; end
        n = 1;
        w = 0;
        while (n < 30 && w < 60) begin tick(); w++; if (gen_tvalid_o) n++; end
        chk("midrun_owner", gnt_o, 4'b0010);
        rst = 1'b1;
        tick();
        chk("midrun_gnt", gnt_o, 0);
        chk("midrun_tvalid", gen_tvalid_o, 0);
        chk("midrun_busy", busy_o, 0);
        chk("midrun_chip_valid", chip_valid_o, 0);
        chk("midrun_done", done_o, 0);
        chk("midrun_code2", gen_code2_o, 0);
        rst = 1'b0;
        w = 0;
        while (gnt_o == '0 && w < 10) begin tick(); w++; end
        chk("midrun_next_grant", gnt_o, 4'b0001);
        req = '0;
        repeat (4) tick();

`ifdef GOLD_SCHED_TIMEOUT_EN
        // ---- ready timeout ----
        do_reset();
        ready = 1'b0;
        req = 4'b0011;
        n = 0;
        while (!err_o && n < 100) begin tick(); n++; end
        chk("tmo_err", err_o, 1);
        chk("tmo_cycle", n, 66);
        chk("tmo_gnt", gnt_o, 0);
        chk("tmo_done", done_o, 0);
        ready = 1'b1;
        w = 0;
        while (gnt_o == '0 && w < 10) begin tick(); w++; end
        chk("tmo_next_grant", gnt_o, 4'b0010);
        req = '0;
        repeat (4) tick();
`endif

        // ---- randomized traffic ----
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            for (int b = 0; b < NREQ; b++)
                if ($urandom_range(0, 250) == 0) req[b] = ~req[b];
            ready = ($urandom_range(0, 4) != 0);
            if ($urandom_range(0, 20) == 0)
                for (int s = 0; s < NREQ; s++) shift[s*LENGTH +: LENGTH] = LENGTH'($urandom);
            rst = ($urandom_range(0, 2999) == 0);
            tick();
        end
        rst = 1'b0;
        req = '0;
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gold_code_scheduler.md
Name: gold_code_scheduler

Overview:
- Sequences and time-shares one Gold code generator (two M-sequence generators XORed; shift-code input, tvalid in, ready out, code out) among NREQ requesters.
- Grants are round-robin. For each grant the block loads the winner's shift code, waits for generator ready, then enables it for exactly REPS full code periods.
- The block returns the chip stream tagged with the owner index, and flags period starts and per-requester completion.

Parameters:
- N, 63, code length in chips.
- LENGTH, $clog2(N), width of the shift code.
- NREQ, 4, number of requesters (>=2).
- IDX_W, $clog2(NREQ), width of the owner index.
- REPS, 2, full code periods issued per grant (>=1).
- TIMEOUT, 64, ready-wait limit in cycles; used only with the optional feature.

Ports:
- clkin  in  1  clock; one clock domain.
- rst  in  1  reset; synchronous, active-high.
- req_i  in  NREQ  level request per requester; held until done or abandoned.
- shift_i  in  NREQ*LENGTH  per-requester shift code; slice k = bits [k*LENGTH +: LENGTH].
- gnt_o  out  NREQ  one-hot grant.
- busy_o  out  1  high in any state other than IDLE.
- gen_code2_o  out  LENGTH  shift code driven to the generator.
- gen_tvalid_o  out  1  generator enable.
- gen_ready_i  in  1  generator ready.
- gen_code_i  in  1  generator Gold chip; valid 1 cycle after gen_tvalid_o.
- chip_o  out  1  chip passed through to the consumer.
- chip_valid_o  out  1  chip_o is valid.
- chip_owner_o  out  IDX_W  requester that owns chip_o.
- period_start_o  out  1  marks chip 0 of each period; aligned with chip_valid_o.
- done_o  out  NREQ  1-cycle completion pulse, one-hot.
- err_o  out  1  1-cycle timeout pulse; tied 0 without the optional feature.

Behaviour:
- Reset (rst=1 at clkin edge):
  - state=IDLE.
  - gnt_o, gen_tvalid_o, chip_valid_o, period_start_o, done_o, err_o, busy_o = 0.
  - gen_code2_o=0, chip_o=0, chip_owner_o=0.
  - chip_cnt=0, per_cnt=0.
  - last_grant=NREQ-1, so requester 0 wins the first arbitration.
  - Reset mid-RUN: gen_tvalid_o drops the next cycle; no done_o pulse.
- IDLE:
  - If any req_i bit is set, winner = first set bit searching upward from last_grant+1 with wrap-around (modulo NREQ).
  - Latch the winner's shift_i slice into gen_code2_o and the winner index as owner; set gnt_o[owner]; go to LOAD.
  - The latched shift code is held stable for the whole grant; later shift_i changes are ignored.
- LOAD: one-cycle settle; go to WAIT_RDY.
- WAIT_RDY:
  - Wait until gen_ready_i=1, then go to RUN with chip_cnt=0 and per_cnt=0.
  - Without the optional feature the wait is unbounded.
- RUN:
  - gen_tvalid_o=1 every cycle.
  - chip_cnt counts 0..N-1 and wraps to 0; per_cnt increments on each wrap.
  - When chip_cnt=N-1 and per_cnt=REPS-1, go to RELEASE. Exactly N*REPS cycles with gen_tvalid_o=1 per grant.
- RELEASE (1 cycle):
  - gen_tvalid_o=0, gnt_o=0.
  - done_o[owner]=1 for a normal finish.
  - last_grant=owner; return to IDLE.
- Minimum gap: 3 cycles from done_o to the next RUN (IDLE, LOAD, WAIT_RDY with ready already high).
- Output datapath: registered, 1-cycle delay after gen_tvalid_o, to match the generator's registered output.
  - chip_valid_o = gen_tvalid_o delayed 1 cycle.
  - chip_o = gen_code_i when chip_valid_o=1, else 0.
  - chip_owner_o = owner delayed 1 cycle.
  - period_start_o = (chip_cnt==0 during RUN) delayed 1 cycle.
- Abandon:
  - req_i[owner] deasserted in LOAD, WAIT_RDY or RUN: go to RELEASE next cycle with no done_o.
  - last_grant=owner, so the abandoning requester loses priority.
- Requests arriving while busy are held off and arbitrated at the next IDLE.
- A requester that keeps req_i high after its done_o is re-arbitrated as a normal request.
- gnt_o is never more than one-hot; done_o is always a subset of the previous cycle's gnt_o.

Optional Feature:
- Macro: GOLD_SCHED_TIMEOUT_EN.
- Defined:
  - WAIT_RDY runs a counter. If gen_ready_i stays low for TIMEOUT consecutive cycles, pulse err_o for 1 cycle and go to RELEASE.
  - No done_o is issued, and last_grant=owner.
  - The counter clears on entering WAIT_RDY.
- Undefined: no counter; err_o tied to 0; WAIT_RDY waits indefinitely.

Test Plan:
- Single request, N=63, REPS=2: req_i=0001, shift_i[0]=5, ready high.
  - gen_code2_o=5 from LOAD.
  - gen_tvalid_o high for exactly 126 cycles; chip_valid_o high for 126 cycles, 1 cycle later.
  - period_start_o pulses at chips 0 and 63.
  - done_o=0001 once; gnt_o=0 after.
- Round-robin, all req_i=1111 held: grant order 0,1,2,3,0; chip_owner_o follows that order; never two gnt_o bits high.
- Abandon: drop req_i[1] after 10 RUN cycles.
  - gen_tvalid_o low within 2 cycles; no done_o.
  - The next grant goes to requester 2, not 1.
- Ready stall: gen_ready_i low 20 cycles after LOAD.
  - gen_tvalid_o stays 0 until ready rises.
  - Then exactly N*REPS enabled cycles.
- Reset mid-RUN at chip 30: next cycle all outputs 0, state IDLE; requester 0 wins the next arbitration.
- With GOLD_SCHED_TIMEOUT_EN, TIMEOUT=64, ready held low:
  - err_o pulses once at wait cycle 64; gnt_o drops; no done_o.
  - The next pending requester is granted.
